// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter sharing a single-port, write-first, registered-output data memory
// between the processor core (P) and a host loader/debug port (H).
module mem_bus_arbiter #(
    parameter int DATA_W     = 16,
    parameter int FIXED_PRIO = 0,
    parameter int MAX_WAIT   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [DATA_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_gnt,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [DATA_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int         P          = 0;
    localparam int         H          = 1;
    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);
    localparam logic [3:0] WAIT_SAT   = 4'd15;

    logic [1:0]        req;
    logic [1:0]        we;
    logic [1:0]        gnt;
    logic [1:0]        rvalid;
    logic [DATA_W-1:0] rdata [2];
    logic [1:0][3:0]   wait_cnt;
    logic              last_gnt_reg;  // 0 = P, 1 = H

    assign req = {h_req, p_req};
    assign we  = {h_we, p_we};

    // Grant is gated by rst_n so reset can never issue a memory write.
    always_comb begin
        gnt = 2'b00;
        if (rst_n) begin
            if (req == 2'b01) begin
                gnt = 2'b01;
            end else if (req == 2'b10) begin
                gnt = 2'b10;
            end else if (req == 2'b11) begin
                if (FIXED_PRIO != 0) begin
                    gnt = (wait_cnt[P] == WAIT_LIMIT) ? 2'b01 : 2'b10;
                end else begin
                    gnt = last_gnt_reg ? 2'b01 : 2'b10;
                end
            end
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wren  = 1'b0;
        if (gnt[P]) begin
            mem_addr  = p_addr;
            mem_wdata = p_wdata;
            mem_wren  = p_we;
        end else if (gnt[H]) begin
            mem_addr  = h_addr;
            mem_wdata = h_wdata;
            mem_wren  = h_we;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_reg <= 1'b0;
        end else if (|gnt) begin
            last_gnt_reg <= gnt[H];
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [3:0]        wait_reg;
        logic              rvalid_reg;
        logic [DATA_W-1:0] hold_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wait_reg   <= 4'd0;
                rvalid_reg <= 1'b0;
                hold_reg   <= '0;
            end else begin
                if (req[gi] && !gnt[gi]) begin
                    wait_reg <= (wait_reg == WAIT_SAT) ? WAIT_SAT : wait_reg + 4'd1;
                end else begin
                    wait_reg <= 4'd0;
                end
                rvalid_reg <= gnt[gi] & ~we[gi];
                if (rvalid_reg) begin
                    hold_reg <= mem_q;
                end
            end
        end

        // The memory output is already registered, so read data passes through in the rvalid cycle.
        assign wait_cnt[gi] = wait_reg;
        assign rvalid[gi]   = rvalid_reg;
        assign rdata[gi]    = rvalid_reg ? mem_q : hold_reg;
    end

    // H's wait count has no consumer in either arbitration mode.
    logic unused_wait_bits;
    assign unused_wait_bits = ^wait_cnt;

    assign p_gnt    = gnt[P];
    assign h_gnt    = gnt[H];
    assign p_rvalid = rvalid[P];
    assign h_rvalid = rvalid[H];
    assign p_rdata  = rdata[P];
    assign h_rdata  = rdata[H];

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Runs a round-robin and a fixed-priority arbiter on identical stimulus, each with its own
// write-first memory, against a cycle-level reference model of the arbitration rules.
module tb_mem_bus_arbiter;

    localparam int MAXW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        p_req, p_we, h_req, h_we;
    logic [15:0] p_addr, p_wdata, h_addr, h_wdata;

    logic        p_gnt [2];
    logic        h_gnt [2];
    logic        p_rvalid [2];
    logic        h_rvalid [2];
    logic        mem_wren [2];
    logic [15:0] p_rdata [2];
    logic [15:0] h_rdata [2];
    logic [15:0] mem_addr [2];
    logic [15:0] mem_wdata [2];
    logic [15:0] mem_q [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic [15:0] bank [0:255];
        logic [15:0] q_reg;

        initial begin
            for (int i = 0; i < 256; i++) bank[i] = 16'h0000;
            q_reg = 16'h0000;
        end

        always @(posedge clk) begin
            if (mem_wren[gi]) begin
                bank[mem_addr[gi][7:0]] <= mem_wdata[gi];
                q_reg <= mem_wdata[gi];
            end else begin
                q_reg <= bank[mem_addr[gi][7:0]];
            end
        end
        assign mem_q[gi] = q_reg;

        mem_bus_arbiter #(.DATA_W(16), .FIXED_PRIO(gi), .MAX_WAIT(MAXW)) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .p_req    (p_req),
            .p_we     (p_we),
            .p_addr   (p_addr),
            .p_wdata  (p_wdata),
            .p_gnt    (p_gnt[gi]),
            .p_rvalid (p_rvalid[gi]),
            .p_rdata  (p_rdata[gi]),
            .h_req    (h_req),
            .h_we     (h_we),
            .h_addr   (h_addr),
            .h_wdata  (h_wdata),
            .h_gnt    (h_gnt[gi]),
            .h_rvalid (h_rvalid[gi]),
            .h_rdata  (h_rdata[gi]),
            .mem_addr (mem_addr[gi]),
            .mem_wdata(mem_wdata[gi]),
            .mem_wren (mem_wren[gi]),
            .mem_q    (mem_q[gi])
        );
    end

    // Reference model state, one set per arbiter instance (0 = round-robin, 1 = fixed priority).
    int          m_last [2];   // 0 = P last granted, 1 = H
    int          m_wp [2];
    bit          m_pv [2];
    bit          m_hv [2];
    logic [15:0] m_pd [2];
    logic [15:0] m_hd [2];
    logic [15:0] ref_mem [2][256];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string tag, input int d, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc %0d: got %h expected %h", tag, d, cyc, got, exp);
        end
    endtask

    function automatic void model_reset(input int d);
        m_last[d] = 0;
        m_wp[d]   = 0;
        m_pv[d]   = 1'b0;
        m_hv[d]   = 1'b0;
        m_pd[d]   = 16'h0000;
        m_hd[d]   = 16'h0000;
    endfunction

    // 0 = no grant, 1 = P, 2 = H
    function automatic int exp_grant(input int d, input bit rn, input bit pr, input bit hr);
        if (!rn) return 0;
        if (pr && !hr) return 1;
        if (hr && !pr) return 2;
        if (!pr && !hr) return 0;
        if (d == 1) return (m_wp[d] == MAXW) ? 1 : 2;
        return (m_last[d] == 0) ? 2 : 1;
    endfunction

    task automatic step(input bit rn,
                        input bit pr, input bit pw, input logic [15:0] pa, input logic [15:0] pd,
                        input bit hr, input bit hw, input logic [15:0] ha, input logic [15:0] hd,
                        input bit mid_rst);
        int g;
        @(negedge clk);
        rst_n = rn; p_req = pr; p_we = pw; p_addr = pa; p_wdata = pd;
        h_req = hr; h_we = hw; h_addr = ha; h_wdata = hd;
        #1;
        for (int d = 0; d < 2; d++) begin
            if (!rn) model_reset(d);
            g = exp_grant(d, rn, pr, hr);
            check("p_gnt", d, p_gnt[d], (g == 1));
            check("h_gnt", d, h_gnt[d], (g == 2));
            check("mem_wren", d, mem_wren[d], (g == 1) ? pw : (g == 2) ? hw : 1'b0);
            check("mem_addr", d, mem_addr[d], (g == 1) ? pa : (g == 2) ? ha : 16'h0000);
            check("mem_wdata", d, mem_wdata[d], (g == 1) ? pd : (g == 2) ? hd : 16'h0000);
            check("p_rvalid", d, p_rvalid[d], m_pv[d]);
            check("h_rvalid", d, h_rvalid[d], m_hv[d]);
            check("p_rdata", d, p_rdata[d], m_pd[d]);
            check("h_rdata", d, h_rdata[d], m_hd[d]);
            if (g != 0)
                $display("[TB] cyc %0d dut%0d grant %s %s addr=%h wdata=%h", cyc, d,
                         (g == 1) ? "P" : "H",
                         ((g == 1) ? pw : hw) ? "WR" : "RD",
                         (g == 1) ? pa : ha, (g == 1) ? pd : hd);
            // Advance the model across the coming rising edge.
            m_pv[d] = (g == 1) && !pw;
            m_hv[d] = (g == 2) && !hw;
            if (g == 1) begin
                if (pw) ref_mem[d][pa[7:0]] = pd;
                else    m_pd[d] = ref_mem[d][pa[7:0]];
            end else if (g == 2) begin
                if (hw) ref_mem[d][ha[7:0]] = hd;
                else    m_hd[d] = ref_mem[d][ha[7:0]];
            end
            m_wp[d] = (pr && g != 1) ? ((m_wp[d] >= 15) ? 15 : m_wp[d] + 1) : 0;
            if (g != 0) m_last[d] = (g == 2) ? 1 : 0;
            if (mid_rst) model_reset(d);
        end
        if (mid_rst) begin
            #1 rst_n = 1'b0;
        end
        cyc++;
    endtask

    initial begin
        rst_n = 1'b0; p_req = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
        h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
        for (int d = 0; d < 2; d++) begin
            model_reset(d);
            for (int i = 0; i < 256; i++) ref_mem[d][i] = 16'h0000;
        end

        // Reset held with both ports requesting writes: no grant, no wren.
        for (int i = 0; i < 3; i++) step(0, 1, 1, 16'h0005, 16'hDEAD, 1, 1, 16'h0006, 16'hBEEF, 0);
        // First conflict after release goes to H.
        step(1, 1, 0, 16'h0003, 16'h0000, 1, 0, 16'h0004, 16'h0000, 0);
        // H preloads 0x00AB at 0x0003, then P reads it alone.
        step(1, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0003, 16'h00AB, 0);
        step(1, 1, 0, 16'h0003, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
        step(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
        // Six cycles of conflicting reads.
        for (int i = 0; i < 6; i++) step(1, 1, 0, 16'h0003, 16'h0000, 1, 0, 16'h0004, 16'h0000, 0);
        step(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
        // Host write followed by processor cross-read of the same address.
        step(1, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0010, 16'h1234, 0);
        step(1, 1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
        step(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
        // Long contention exposes the 4:1 forced-grant pattern in fixed priority.
        for (int i = 0; i < 12; i++) step(1, 1, 0, 16'h0010, 16'h0000, 1, 0, 16'h0003, 16'h0000, 0);
        // Randomised traffic over a small address window to force collisions.
        for (int i = 0; i < 250; i++)
            step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)),
                 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 16'($urandom_range(0, 15)), 16'($urandom), 0);
        // Reset lands after a granted read but before its data returns.
        step(1, 1, 0, 16'h0003, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1);
        step(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
        step(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
        step(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
